// File: rtl/ram_controller_if.sv
// ALU memory-port bundle between the ALU (master) and the RAM responder (slave).
// Carries the request/acknowledge handshake, the address and data buses, and the error pulses.
interface ram_controller_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ramAddress;
  logic [DATA_WIDTH-1:0] ramOut;
  logic [DATA_WIDTH-1:0] ramIn;
  logic                  readReq;
  logic                  writeReq;
  logic                  readAck;
  logic                  writeAck;
  logic                  misalign;
  logic                  protoErr;

  modport master (
    output ramAddress, ramOut, readReq, writeReq,
    input  ramIn, readAck, writeAck, misalign, protoErr
  );

  modport slave (
    input  ramAddress, ramOut, readReq, writeReq,
    output ramIn, readAck, writeAck, misalign, protoErr
  );
endinterface

// File: rtl/ram_controller.sv
// Word-wide RAM responder for the ALU memory port: four-phase req/ack with a configurable
// latency per direction, plus a preload port that writes the array in any state.
module ram_controller #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_controller_if.slave       bus,
  input  logic                  loadEn,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [DATA_WIDTH-1:0] loadData
);
  localparam int IW      = ADDR_WIDTH - 2;
  localparam int DEPTH   = 2 ** IW;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  dir_reg;
  logic                  read_ack_reg, write_ack_reg, misalign_reg, proto_err_reg;
  logic [DATA_WIDTH-1:0] ram_in_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req_any, active_req, accept, commit, ack_clear, c_wr, mem_we;
  logic [IW-1:0]         req_idx, load_idx, c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  int                    lat_sel;

  assign req_idx    = IW'(bus.ramAddress >> 2);
  assign load_idx   = IW'(loadAddr >> 2);
  assign req_any    = bus.readReq | bus.writeReq;
  assign active_req = dir_reg ? bus.writeReq : bus.readReq;
  // Write wins when both requests are raised together.
  assign lat_sel    = bus.writeReq ? WRITE_LATENCY : READ_LATENCY;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = (lat_sel == 1) ? ACK : BUSY;
      BUSY:    if (!active_req) state_next = IDLE;
               else if (cnt_reg == CW'(1)) state_next = ACK;
      ACK:     if (!active_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle transactions commit straight from the live bus rather than the latches.
  always_comb begin
    accept    = 1'b0;
    commit    = 1'b0;
    ack_clear = 1'b0;
    c_wr      = dir_reg;
    c_idx     = idx_reg;
    c_data    = data_reg;
    case (state_reg)
      IDLE: begin
        accept = req_any;
        commit = req_any && (lat_sel == 1);
        c_wr   = bus.writeReq;
        c_idx  = req_idx;
        c_data = bus.ramOut;
      end
      BUSY:    commit    = active_req && (cnt_reg == CW'(1));
      ACK:     ack_clear = !active_req;
      default: ;
    endcase
  end

  assign mem_we = commit && c_wr && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      data_reg      <= '0;
      dir_reg       <= 1'b0;
      read_ack_reg  <= 1'b0;
      write_ack_reg <= 1'b0;
      misalign_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
      ram_in_reg    <= '0;
    end else begin
      misalign_reg  <= accept && (bus.ramAddress[1:0] != 2'b00);
      proto_err_reg <= accept && bus.readReq && bus.writeReq;
      if (accept) begin
        cnt_reg  <= CW'(lat_sel - 1);
        idx_reg  <= req_idx;
        data_reg <= bus.ramOut;
        dir_reg  <= bus.writeReq;
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (commit) begin
        if (c_wr) begin
          write_ack_reg <= 1'b1;
        end else begin
          read_ack_reg <= 1'b1;
          // A preload landing on the sampled word this edge is forwarded.
          ram_in_reg   <= (loadEn && load_idx == c_idx) ? loadData : mem[c_idx];
        end
      end else if (ack_clear) begin
        read_ack_reg  <= 1'b0;
        write_ack_reg <= 1'b0;
      end
    end
  end

  // Array is never cleared; a write commit beats a preload to the same word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_data;
    if (loadEn && !(mem_we && load_idx == c_idx)) mem[load_idx] <= loadData;
  end

  assign bus.ramIn    = ram_in_reg;
  assign bus.readAck  = read_ack_reg;
  assign bus.writeAck = write_ack_reg;
  assign bus.misalign = misalign_reg;
  assign bus.protoErr = proto_err_reg;
endmodule

// File: tb/tb_ram_controller.sv
// Self-checking bench: two responders (write latency 1 and 3) share stimulus, one is
// selected per transaction; expectations come from a word-array model and latency rules.
module tb_ram_controller;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          loadEn;
  logic [AW-1:0] loadAddr;
  logic [DW-1:0] loadData;
  logic          sel;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_rd, a_wr;
  logic          o_rack, o_wack, o_mis, o_perr;
  logic [DW-1:0] o_ramin;
  logic [DW-1:0] mem_m [2][64];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  ram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  assign bus0.ramAddress = a_addr;
  assign bus0.ramOut     = a_data;
  assign bus0.readReq    = a_rd & ~sel;
  assign bus0.writeReq   = a_wr & ~sel;
  assign bus3.ramAddress = a_addr;
  assign bus3.ramOut     = a_data;
  assign bus3.readReq    = a_rd & sel;
  assign bus3.writeReq   = a_wr & sel;

  assign o_rack  = sel ? bus3.readAck  : bus0.readAck;
  assign o_wack  = sel ? bus3.writeAck : bus0.writeAck;
  assign o_mis   = sel ? bus3.misalign : bus0.misalign;
  assign o_perr  = sel ? bus3.protoErr : bus0.protoErr;
  assign o_ramin = sel ? bus3.ramIn    : bus0.ramIn;

  ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .bus(bus0),
    .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
  );

  ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .WRITE_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    loadEn   = 1'b1;
    loadAddr = addr;
    loadData = data;
    tick();
    loadEn = 1'b0;
    mem_m[0][addr[7:2]] = data;
    mem_m[1][addr[7:2]] = data;
  endtask

  // One complete four-phase transaction on the selected responder.
  task automatic txn(input logic wr, input logic both, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input string tag);
    int            lat, cyc;
    logic          got, wrong, effwr;
    logic [5:0]    idx;
    logic [DW-1:0] exp;
    effwr = wr | both;
    idx   = addr[7:2];
    lat   = effwr ? (sel ? 3 : 1) : 2;
    exp   = mem_m[sel][idx];
    a_addr = addr;
    a_data = data;
    a_wr   = effwr;
    a_rd   = both | ~wr;
    cyc = 0; got = 1'b0; wrong = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (o_mis !== (addr[1:0] != 2'b00) || o_perr !== both) begin
          errors++;
          $display("FAIL %s pulses: misalign=%b protoErr=%b required %b %b",
                   tag, o_mis, o_perr, (addr[1:0] != 2'b00), both);
        end
      end
      got = effwr ? o_wack : o_rack;
      if ((effwr ? o_rack : o_wack) !== 1'b0) wrong = 1'b1;
    end
    checks++;
    if (got !== 1'b1 || cyc != lat || wrong) begin
      errors++;
      $display("FAIL %s latency: ack=%b after %0d cycles wrong_ack=%b, required ack after %0d",
               tag, got, cyc, wrong, lat);
    end
    if (!effwr) begin
      checks++;
      if (o_ramin !== exp) begin
        errors++;
        $display("FAIL %s data: ramIn=%h required %h", tag, o_ramin, exp);
      end
    end else begin
      mem_m[sel][idx] = data;
    end
    tick();
    checks++;
    if ((effwr ? o_wack : o_rack) !== 1'b1 || o_mis !== 1'b0 || o_perr !== 1'b0 ||
        (!effwr && o_ramin !== exp)) begin
      errors++;
      $display("FAIL %s hold: ack=%b misalign=%b protoErr=%b ramIn=%h, required ack=1 pulses=0",
               tag, effwr ? o_wack : o_rack, o_mis, o_perr, o_ramin);
    end
    a_rd = 1'b0;
    a_wr = 1'b0;
    tick();
    checks++;
    if (o_rack !== 1'b0 || o_wack !== 1'b0 || (!effwr && o_ramin !== exp)) begin
      errors++;
      $display("FAIL %s drop: readAck=%b writeAck=%b ramIn=%h, required 0 0 %h",
               tag, o_rack, o_wack, o_ramin, effwr ? o_ramin : exp);
    end
    $display("txn %s sel=%0d %s addr=%h data=%h cycles=%0d", tag, sel,
             effwr ? "WR" : "RD", addr, effwr ? data : o_ramin, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_data = '0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0;
    repeat (3) tick();
    checks++;
    if ({bus0.readAck, bus0.writeAck, bus0.misalign, bus0.protoErr} !== 4'b0 || bus0.ramIn !== '0) begin
      errors++;
      $display("FAIL reset_dut: acks/pulses=%b ramIn=%h required 0", 
               {bus0.readAck, bus0.writeAck, bus0.misalign, bus0.protoErr}, bus0.ramIn);
    end
    checks++;
    if ({bus3.readAck, bus3.writeAck, bus3.misalign, bus3.protoErr} !== 4'b0 || bus3.ramIn !== '0) begin
      errors++;
      $display("FAIL reset_dut3: acks/pulses=%b ramIn=%h required 0",
               {bus3.readAck, bus3.writeAck, bus3.misalign, bus3.protoErr}, bus3.ramIn);
    end
    // Preload while held in reset; low address bits are random and must be ignored.
    for (int i = 0; i < 64; i++) begin
      logic [5:0]    w;
      logic [1:0]    lo;
      logic [DW-1:0] d;
      w  = 6'(i);
      lo = 2'($urandom);
      d  = $urandom;
      if (i == 1) d = 32'hDEADBEEF;
      if (i == 8 || i == 9) d = '0;
      load_word({w, lo}, d);
    end
    reset = 1'b0;
    tick();
    $display("txn reset+preload done");
  endtask

  task automatic test_basic();
    sel = 1'b0;
    txn(1'b0, 1'b0, 8'h04, 32'h0, "preload_read");
    txn(1'b1, 1'b0, 8'h10, 32'h12345678, "write_10");
    txn(1'b0, 1'b0, 8'h10, 32'h0, "read_10");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    txn(1'b0, 1'b0, 8'h00, 32'h0, "b2b_rd0");
    txn(1'b0, 1'b0, 8'h08, 32'h0, "b2b_rd8");
    txn(1'b1, 1'b0, 8'h08, $urandom, "b2b_wr8");
    txn(1'b0, 1'b0, 8'h08, 32'h0, "b2b_rd8b");
  endtask

  task automatic test_proto_misalign();
    sel = 1'b0;
    txn(1'b0, 1'b1, 8'h0C, 32'hA5A5A5A5, "both_0C");
    txn(1'b0, 1'b0, 8'h0E, 32'h0, "misalign_0E");
  endtask

  task automatic test_abort();
    logic seen;
    sel = 1'b1;
    a_addr = 8'h20; a_data = $urandom; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (o_wack !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_ack: writeAck seen=%b required 0", seen);
    end
    txn(1'b0, 1'b0, 8'h20, 32'h0, "abort_read20");
    // Reset while a slow write is in flight discards it.
    a_addr = 8'h24; a_data = $urandom; a_wr = 1'b1;
    tick();
    reset = 1'b1; a_wr = 1'b0;
    tick();
    checks++;
    if (o_wack !== 1'b0 || o_rack !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_acks: writeAck=%b readAck=%b required 0 0", o_wack, o_rack);
    end
    reset = 1'b0;
    txn(1'b0, 1'b0, 8'h24, 32'h0, "reset_read24");
    // Reset during a read with the request held: serviced again straight from IDLE.
    sel = 1'b0;
    a_addr = 8'h04; a_rd = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (o_rack !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_ack: readAck=%b required 0", o_rack);
    end
    repeat (2) tick();
    checks++;
    if (o_rack !== 1'b1 || o_ramin !== mem_m[0][1]) begin
      errors++;
      $display("FAIL reset_read_resume: readAck=%b ramIn=%h required 1 %h", o_rack, o_ramin, mem_m[0][1]);
    end
    a_rd = 1'b0;
    tick();
    $display("txn abort/reset scenarios done");
  endtask

  task automatic test_collision();
    logic [DW-1:0] wa, lb;
    sel = 1'b0;
    wa = $urandom; lb = ~wa;
    a_addr = 8'h30; a_data = wa; a_wr = 1'b1;
    loadEn = 1'b1; loadAddr = 8'h31; loadData = lb;
    tick();
    loadEn = 1'b0;
    mem_m[0][12] = wa;
    mem_m[1][12] = lb;
    checks++;
    if (o_wack !== 1'b1) begin
      errors++;
      $display("FAIL collision_ack: writeAck=%b required 1", o_wack);
    end
    a_wr = 1'b0;
    tick();
    $display("txn collision write=%h load=%h", wa, lb);
    txn(1'b0, 1'b0, 8'h30, 32'h0, "collision_rd0");
    sel = 1'b1;
    txn(1'b0, 1'b0, 8'h30, 32'h0, "collision_rd3");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom);
      if ($urandom_range(0, 3) == 0) tick();
      txn(1'($urandom), ($urandom_range(0, 5) == 0), 8'($urandom), $urandom, "rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_proto_misalign();
    test_abort();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
